// File: rtl/gray_histogram_if.sv
// Pixel-in and histogram-out streams of gray_histogram. The slave modport is the histogram
// block; the master modport is the upstream/downstream environment.
interface gray_histogram_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 19
);
  logic [PIX_W-1:0] Gray;
  logic             Done_one;
  logic             Done_full;
  logic             in_ready;
  logic [PIX_W-1:0] hist_bin;
  logic [CNT_W-1:0] hist_cnt;
  logic             hist_valid;
  logic             hist_ready;
  logic             hist_last;

  modport master (
    output Gray, Done_one, Done_full, hist_ready,
    input  in_ready, hist_bin, hist_cnt, hist_valid, hist_last
  );

  modport slave (
    input  Gray, Done_one, Done_full, hist_ready,
    output in_ready, hist_bin, hist_cnt, hist_valid, hist_last
  );
endinterface

// File: rtl/gray_histogram.sv
// 256-bin luminance histogram of one gray frame, streamed out bin by bin over valid/ready.
// Bins are cleared, accumulated through a 2-stage read/increment pipeline, then drained.
module gray_histogram #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned NUM_PIX = 262144,
  parameter int unsigned CNT_W   = 19
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  gray_histogram_if.slave  bus,
  output logic             busy,
  output logic             Done_hist,
  output logic             err_drop
);
  localparam int unsigned Bins = 2 ** PIX_W;
  localparam int unsigned PcW  = $clog2(NUM_PIX + 1);
  localparam logic [PIX_W-1:0] LastBin = PIX_W'(Bins - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [2:0] {StIdle, StClear, StAccum, StFlush, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [PIX_W-1:0] idx_q, idx_d;
  logic [PcW-1:0]   pix_cnt_q, pix_cnt_d;
  logic             flush_q, flush_d;
  logic             err_q, err_d;

  logic             s1_valid_q;
  logic [PIX_W-1:0] s1_pix_q;
  logic [CNT_W-1:0] s1_cnt_q;

  logic [CNT_W-1:0] mem [Bins];

  logic             accept;
  logic [CNT_W-1:0] s1_inc;
  logic [CNT_W-1:0] rd_fwd;
  logic             we;
  logic [PIX_W-1:0] waddr;
  logic [CNT_W-1:0] wdata;

  assign accept = (state_q == StAccum) && bus.Done_one;
  assign s1_inc = (s1_cnt_q == CntMax) ? s1_cnt_q : s1_cnt_q + CNT_W'(1);
  // The stage-2 write lands at the end of this cycle, so an equal pixel now must take it directly.
  assign rd_fwd = (s1_valid_q && (s1_pix_q == bus.Gray)) ? s1_inc : mem[bus.Gray];

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (state_q == StClear) begin
      we    = 1'b1;
      waddr = idx_q;
    end else if (s1_valid_q) begin
      we    = 1'b1;
      waddr = s1_pix_q;
      wdata = s1_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pix_cnt_d = pix_cnt_q;
    flush_d   = flush_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        if (start) begin
          state_d   = StClear;
          pix_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      StClear: begin
        idx_d = idx_q + PIX_W'(1);
        if (idx_q == LastBin) state_d = StAccum;
      end
      StAccum: begin
        flush_d = 1'b0;
        if (accept) pix_cnt_d = pix_cnt_q + PcW'(1);
        if (bus.Done_full || (accept && (pix_cnt_q == PcW'(NUM_PIX - 1)))) state_d = StFlush;
      end
      StFlush: begin
        flush_d = ~flush_q;
        if (flush_q) state_d = StDrain;
      end
      StDrain: begin
        // idx wraps back to 0 after the last bin, ready for the next frame
        if (bus.hist_ready) begin
          idx_d = idx_q + PIX_W'(1);
          if (idx_q == LastBin) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.Done_one && (state_q != StAccum)) err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      pix_cnt_q  <= '0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
      s1_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pix_cnt_q  <= pix_cnt_d;
      flush_q    <= flush_d;
      err_q      <= err_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_pix_q <= bus.Gray;
        s1_cnt_q <= rd_fwd;
      end
    end
  end

  assign bus.in_ready   = (state_q == StAccum);
  assign bus.hist_valid = (state_q == StDrain);
  assign bus.hist_bin   = (state_q == StDrain) ? idx_q : '0;
  assign bus.hist_cnt   = (state_q == StDrain) ? mem[idx_q] : '0;
  assign bus.hist_last  = (state_q == StDrain) && (idx_q == LastBin);
  assign busy           = (state_q != StIdle);
  assign Done_hist      = (state_q == StDone);
  assign err_drop       = err_q;
endmodule

// File: tb/tb_gray_histogram.sv
// Directed bench for gray_histogram: a reduced-frame instance for counting/hazard/stall cases
// and a 4-bit-counter instance for saturation; drained words are checked against a scoreboard.
module tb_gray_histogram;
  localparam int unsigned BigNum = 1024;

  logic CLK;
  logic RST;
  logic start, busy, done_hist, err_drop;
  logic s_start, s_busy, s_done, s_err;

  gray_histogram_if #(.PIX_W(8), .CNT_W(19)) bif ();
  gray_histogram_if #(.PIX_W(8), .CNT_W(4))  sif ();

  gray_histogram #(.PIX_W(8), .NUM_PIX(BigNum), .CNT_W(19)) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .bus       (bif),
    .busy      (busy),
    .Done_hist (done_hist),
    .err_drop  (err_drop)
  );

  gray_histogram #(.PIX_W(8), .NUM_PIX(64), .CNT_W(4)) u_sat (
    .CLK       (CLK),
    .RST       (RST),
    .start     (s_start),
    .bus       (sif),
    .busy      (s_busy),
    .Done_hist (s_done),
    .err_drop  (s_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  bin;
    logic [18:0] cnt;
    logic        last;
  } word_t;

  word_t       sb [$];
  logic [18:0] m_hist [256];
  int          m_pc;
  bit          m_open;
  int          total = 0;
  int          bad   = 0;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    int lat;
    for (int b = 0; b < 256; b++) m_hist[b] = '0;
    m_pc   = 0;
    m_open = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_clear_on_start", err_drop, 0);
    lat = 1;
    while (!bif.in_ready && lat < 400) begin
      tick();
      lat++;
    end
    check("accum_latency", lat, 257);
  endtask

  task automatic feed(input logic [7:0] p, input bit full);
    if (m_open) begin
      if (m_hist[p] != 19'h7FFFF) m_hist[p] = m_hist[p] + 19'd1;
      m_pc++;
      if (full || m_pc == BigNum) m_open = 1'b0;
    end
    bif.Gray      = p;
    bif.Done_one  = 1'b1;
    bif.Done_full = full;
    tick();
    bif.Done_one  = 1'b0;
    bif.Done_full = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    bit    pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int    n   = 0;
    int    cyc = 0;
    int    k   = 0;
    bit    r;
    word_t w;
    sb.delete();
    for (int b = 0; b < 256; b++) begin
      w.bin  = 8'(b);
      w.cnt  = m_hist[b];
      w.last = (b == 255);
      sb.push_back(w);
    end
    while (n < 256 && cyc < 3000) begin
      if (bif.hist_valid) begin
        w = sb[0];
        check("hist_bin", bif.hist_bin, w.bin);
        check("hist_cnt", bif.hist_cnt, w.cnt);
        check("hist_last", bif.hist_last, w.last);
        r = toggle ? pat[k % 4] : 1'b1;
        k++;
        bif.hist_ready = r;
        if (r) begin
          void'(sb.pop_front());
          n++;
        end
      end else begin
        if (n > 0) check("valid_hold", bif.hist_valid, 1);
        bif.hist_ready = 1'b0;
      end
      tick();
      cyc++;
    end
    bif.hist_ready = 1'b0;
    check("drain_transfers", n, 256);
    check("done_pulse", done_hist, 1);
    check("valid_after_last", bif.hist_valid, 0);
    tick();
    check("done_one_cycle", done_hist, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int n;
    int cyc;
    RST            = 1'b1;
    start          = 1'b0;
    s_start        = 1'b0;
    bif.Gray       = '0;
    bif.Done_one   = 1'b0;
    bif.Done_full  = 1'b0;
    bif.hist_ready = 1'b0;
    sif.Gray       = '0;
    sif.Done_one   = 1'b0;
    sif.Done_full  = 1'b0;
    sif.hist_ready = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_in_ready", bif.in_ready, 0);
    check("rst_hist_valid", bif.hist_valid, 0);
    check("rst_hist_last", bif.hist_last, 0);
    check("rst_done", done_hist, 0);
    check("rst_err", err_drop, 0);
    check("rst_bin", bif.hist_bin, 0);
    check("rst_cnt", bif.hist_cnt, 0);

    // Constant frame that ends on the pixel count
    start_frame();
    for (int i = 0; i < BigNum; i++) feed(8'h80, 1'b0);
    check("count_exit", bif.in_ready, 0);
    drain(1'b0);
    check("no_err_full_frame", err_drop, 0);

    // Ramp frame drained with a stalling consumer
    start_frame();
    for (int i = 0; i < BigNum; i++) feed(8'(i % 256), 1'b0);
    drain(1'b1);

    // Read-modify-write hazards, closing on Done_full
    start_frame();
    feed(8'd5, 1'b0);
    feed(8'd5, 1'b0);
    feed(8'd5, 1'b0);
    feed(8'd7, 1'b0);
    feed(8'd5, 1'b0);
    feed(8'd5, 1'b0);
    tick();
    feed(8'd5, 1'b1);
    check("full_exit", bif.in_ready, 0);
    check("bin5_model", m_hist[5], 6);
    drain(1'b0);

    // Pixel while idle, then reset in the middle of a drain
    bif.Done_one = 1'b1;
    tick();
    bif.Done_one = 1'b0;
    check("err_idle_pixel", err_drop, 1);
    start_frame();
    feed(8'd1, 1'b0);
    feed(8'd2, 1'b1);
    n = 0;
    while (!bif.hist_valid && n < 20) begin
      tick();
      n++;
    end
    check("reach_drain", bif.hist_valid, 1);
    bif.hist_ready = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST            = 1'b0;
    bif.hist_ready = 1'b0;
    check("midrst_valid", bif.hist_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_bin", bif.hist_bin, 0);
    check("midrst_cnt", bif.hist_cnt, 0);
    check("midrst_err", err_drop, 0);
    tick();
    check("midrst_stay_idle", busy, 0);

    // Saturating 4-bit counters
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n = 0;
    while (!sif.in_ready && n < 400) begin
      tick();
      n++;
    end
    check("sat_ready", sif.in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      sif.Gray      = 8'h33;
      sif.Done_one  = 1'b1;
      sif.Done_full = (i == 19);
      tick();
    end
    sif.Done_one   = 1'b0;
    sif.Done_full  = 1'b0;
    sif.hist_ready = 1'b1;
    n   = 0;
    cyc = 0;
    while (n < 256 && cyc < 1000) begin
      if (sif.hist_valid) begin
        check("sat_bin", sif.hist_bin, n);
        check("sat_cnt", sif.hist_cnt, (n == 8'h33) ? 15 : 0);
        n++;
      end
      tick();
      cyc++;
    end
    sif.hist_ready = 1'b0;
    check("sat_transfers", n, 256);
    check("sat_done", s_done, 1);
    tick();
    check("sat_idle", s_busy, 0);
    check("sat_err", s_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
